// File: rtl/bb_mem_arbiter.sv
// rtl/bb_mem_arbiter.sv - two-requester round-robin arbiter for one single-port memory
//
// Shares one single-port program memory between the bb_core instruction/data
// bus (port 0) and an external loader/debug requester (port 1). Accesses are
// serialised by a four-state FSM. The memory strobes are registered. Reads
// count a fixed latency and then return data with a one-cycle valid pulse to
// the port that owns the access.
//
// Parameters
//   DATA_WIDTH  address and data width (matches DATA_WIDTH in define.v)
//   RD_LAT      memory read latency in cycles, legal range 1..4
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   i_req0/1                access request, held until the matching grant
//   i_we0/1                 1 = write, 0 = read
//   i_addr0/1, i_wdata0/1   access address and write data
//   i_lock1                 port 1 bus-lock request
//   o_gnt0/1                one-cycle grant pulse, aligned with o_mem_cs
//   o_rvalid0/1             one-cycle read-data-valid pulse
//   o_rdata                 registered read data, qualified by o_rvalidN
//   o_mem_cs, o_mem_we      memory chip select and write enable
//   o_mem_addr, o_mem_wdata memory address and write data (qualified by o_mem_cs)
//   i_mem_rdata             memory read data, valid RD_LAT cycles after o_mem_cs
//
// Build option
//   BB_ARB_LOCK_EN  when defined, port 1 can hold the bus with i_lock1;
//                   when undefined, i_lock1 is ignored and pure round-robin applies.

module bb_mem_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req0,
    input  logic                  i_we0,
    input  logic [DATA_WIDTH-1:0] i_addr0,
    input  logic [DATA_WIDTH-1:0] i_wdata0,
    input  logic                  i_req1,
    input  logic                  i_we1,
    input  logic [DATA_WIDTH-1:0] i_addr1,
    input  logic [DATA_WIDTH-1:0] i_wdata1,
    input  logic                  i_lock1,
    output logic                  o_gnt0,
    output logic                  o_gnt1,
    output logic                  o_rvalid0,
    output logic                  o_rvalid1,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_mem_cs,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Counter is loaded with RD_LAT-1, so two bits cover the 1..4 range.
    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    state_t     state;
    logic       owner;      // 0 = port 0, 1 = port 1 owns the current access
    logic       last_gnt;   // port granted most recently
    logic [1:0] lat_cnt;

    logic       sel_valid;
    logic       sel_port;

`ifdef BB_ARB_LOCK_EN
    // Set by a port-1 access; while set, i_lock1 in IDLE keeps port 1 as the
    // only candidate. Cleared by a port-0 access or by i_lock1 low in IDLE.
    logic lock_arm;
    logic lock_active;

    assign lock_active = lock_arm & i_lock1;
`else
    logic unused_lock;

    assign unused_lock = i_lock1;
`endif

    // Round-robin selection: on a tie the port not granted last wins.
    // last_gnt resets to 1 so port 0 wins the first tie.
    always_comb begin
        sel_valid = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            sel_port = ~last_gnt;
        end else begin
            sel_port = i_req1;
        end
`ifdef BB_ARB_LOCK_EN
        // A locked bus idles rather than serving port 0.
        if (lock_active) begin
            sel_valid = i_req1;
            sel_port  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            owner       <= 1'b0;
            last_gnt    <= 1'b1;
            lat_cnt     <= 2'd0;
            o_gnt0      <= 1'b0;
            o_gnt1      <= 1'b0;
            o_rvalid0   <= 1'b0;
            o_rvalid1   <= 1'b0;
            o_rdata     <= '0;
            o_mem_cs    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
`ifdef BB_ARB_LOCK_EN
            lock_arm    <= 1'b0;
`endif
        end else begin
            // Pulsed outputs default low; the memory address/data/we hold.
            o_gnt0    <= 1'b0;
            o_gnt1    <= 1'b0;
            o_rvalid0 <= 1'b0;
            o_rvalid1 <= 1'b0;
            o_mem_cs  <= 1'b0;

            case (state)
                S_IDLE: begin
`ifdef BB_ARB_LOCK_EN
                    if (!i_lock1) begin
                        lock_arm <= 1'b0;
                    end
`endif
                    if (sel_valid) begin
                        owner       <= sel_port;
                        o_mem_cs    <= 1'b1;
                        o_mem_we    <= sel_port ? i_we1    : i_we0;
                        o_mem_addr  <= sel_port ? i_addr1  : i_addr0;
                        o_mem_wdata <= sel_port ? i_wdata1 : i_wdata0;
                        o_gnt0      <= ~sel_port;
                        o_gnt1      <= sel_port;
                        state       <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    last_gnt <= owner;
`ifdef BB_ARB_LOCK_EN
                    lock_arm <= owner;
`endif
                    if (o_mem_we) begin
                        state <= S_IDLE;
                    end else begin
                        // With RD_LAT = 1 the count is already 0 and WAIT
                        // captures on its first cycle.
                        lat_cnt <= LAT_LOAD;
                        state   <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        o_rdata   <= i_mem_rdata;
                        o_rvalid0 <= ~owner;
                        o_rvalid1 <= owner;
                        state     <= S_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end

                S_RESP: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
